// File: rtl/psk_ctrl_pkg.sv
// PSK transmit control-plane shared definitions.
// Scheduler states, modulation modes and Tx config widths.
package psk_ctrl_pkg;

    localparam int MODE_W  = 2;
    localparam int PHASE_W = 2;
    localparam int DELAY_W = 8;
    localparam int CNT_W   = 8;

    localparam logic [MODE_W-1:0] MODE_BPSK  = 2'd0;
    localparam logic [MODE_W-1:0] MODE_QPSK  = 2'd1;
    localparam logic [MODE_W-1:0] MODE_DBPSK = 2'd2;
    localparam logic [MODE_W-1:0] MODE_DQPSK = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARM       = 3'd1,
        S_START     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4,
        S_ERR       = 3'd5
    } sched_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sched_timer.sv
// Loadable down-counter with zero flag.
// Shared by the settle, gap and watchdog intervals.
module sched_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/tx_burst_sched.sv
// Tx burst scheduler: config latch, frame launch sequencing
// and per-frame watchdog for the PSK transmit chain.
module tx_burst_sched
    import psk_ctrl_pkg::*;
#(
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 4096,
    parameter int GAP_W       = 16
) (
    input  logic               clk_1d024M,
    input  logic               rst_n_1d024M,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MODE_W-1:0]  cfg_mode,
    input  logic [PHASE_W-1:0] cfg_phase,
    input  logic [DELAY_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0]   cfg_burst_len,
    input  logic [GAP_W-1:0]   cfg_gap,
    input  logic               run,
    input  logic               abort,
    input  logic               tx_frame_done,
    output logic [MODE_W-1:0]  MODE_CTRL,
    output logic [PHASE_W-1:0] TX_PHASE_CONFIG,
    output logic [DELAY_W-1:0] DELAY_CNT,
    output logic               tx_en,
    output logic               tx_start,
    output logic               busy,
    output logic               burst_done,
    output logic [CNT_W-1:0]   frame_cnt,
    output logic               err
);

    localparam int TW = max2(GAP_W,
                        max2($clog2(TIMEOUT_CYC), $clog2(SETTLE_CYC)));

    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] WD_LD     = TW'(TIMEOUT_CYC - 1);

    sched_state_t     state;
    sched_state_t     state_d;
    logic [CNT_W-1:0] burst_q;
    logic [GAP_W-1:0] gap_q;
    logic             cfg_loaded;
    logic             cfg_hs;
    logic             fdone;
    logic             last_frame;
    logic [CNT_W-1:0] cnt_inc;
    logic             t_load;
    logic [TW-1:0]    t_val;
    logic             t_zero;

    assign cfg_hs     = cfg_valid && cfg_ready;
    assign fdone      = (state == S_WAIT_DONE) && tx_frame_done;
    assign cnt_inc    = frame_cnt + CNT_W'(1);
    assign last_frame = fdone && (burst_q != '0) && (cnt_inc == burst_q);

    sched_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk_1d024M),
        .rst_n    (rst_n_1d024M),
        .load     (t_load),
        .load_val (t_val),
        .zero     (t_zero)
    );

    always_comb begin
        state_d = state;
        t_load  = 1'b0;
        t_val   = '0;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (run && cfg_loaded && !err && !cfg_hs) begin
                        state_d = S_ARM;
                        t_load  = 1'b1;
                        t_val   = SETTLE_LD;
                    end
                end
                S_ARM: begin
                    if (t_zero) state_d = S_START;
                end
                S_START: begin
                    state_d = S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    // a done arriving on the expiry cycle still counts
                    if (fdone) begin
                        if (last_frame || !run) begin
                            state_d = S_IDLE;
                        end else if (gap_q == '0) begin
                            state_d = S_START;
                        end else begin
                            state_d = S_GAP;
                            t_load  = 1'b1;
                            t_val   = TW'(gap_q) - TW'(1);
                        end
                    end else if (t_zero) begin
                        state_d = S_ERR;
                    end
                end
                S_GAP: begin
                    if (t_zero) state_d = run ? S_START : S_IDLE;
                end
                S_ERR: begin
                    if (!run) state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
            // watchdog arms on entry to START and counts through it
            if (state_d == S_START) begin
                t_load = 1'b1;
                t_val  = WD_LD;
            end
        end
    end

    always_ff @(posedge clk_1d024M) begin
        if (!rst_n_1d024M) begin
            state           <= S_IDLE;
            cfg_loaded      <= 1'b0;
            cfg_ready       <= 1'b0;
            burst_q         <= '0;
            gap_q           <= '0;
            MODE_CTRL       <= '0;
            TX_PHASE_CONFIG <= '0;
            DELAY_CNT       <= '0;
            tx_en           <= 1'b0;
            tx_start        <= 1'b0;
            busy            <= 1'b0;
            burst_done      <= 1'b0;
            frame_cnt       <= '0;
            err             <= 1'b0;
        end else begin
            state      <= state_d;
            cfg_ready  <= (state_d == S_IDLE);
            tx_en      <= state_d inside {S_ARM, S_START,
                                          S_WAIT_DONE, S_GAP};
            tx_start   <= (state_d == S_START);
            busy       <= (state_d != S_IDLE);
            burst_done <= last_frame && !abort;

            if (state == S_IDLE && state_d == S_ARM) begin
                frame_cnt <= '0;
            end else if (fdone) begin
                frame_cnt <= cnt_inc;
            end

            if (state_d == S_ERR && state != S_ERR) begin
                err <= 1'b1;
            end else if (cfg_hs) begin
                err <= 1'b0;
            end

            if (cfg_hs) begin
                MODE_CTRL       <= cfg_mode;
                TX_PHASE_CONFIG <= cfg_phase;
                DELAY_CNT       <= cfg_delay;
                burst_q         <= cfg_burst_len;
                gap_q           <= cfg_gap;
                cfg_loaded      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tx_burst_sched.sv
// Bench for tx_burst_sched: directed scenarios plus random traffic,
// checked against a timestamp-based model of the scheduling rules.
module tb_tx_burst_sched;

    localparam int SETTLE = 16;
    localparam int TMO    = 4096;

    localparam int P_OFF    = 0;
    localparam int P_SETTLE = 1;
    localparam int P_LAUNCH = 2;
    localparam int P_FLIGHT = 3;
    localparam int P_REST   = 4;
    localparam int P_FAULT  = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_mode;
    logic [1:0]  cfg_phase;
    logic [7:0]  cfg_delay;
    logic [7:0]  cfg_burst_len;
    logic [15:0] cfg_gap;
    logic        run;
    logic        abort;
    logic        tx_frame_done;
    logic [1:0]  MODE_CTRL;
    logic [1:0]  TX_PHASE_CONFIG;
    logic [7:0]  DELAY_CNT;
    logic        tx_en;
    logic        tx_start;
    logic        busy;
    logic        burst_done;
    logic [7:0]  frame_cnt;
    logic        err;

    always #5 clk = ~clk;

    tx_burst_sched #(
        .SETTLE_CYC  (SETTLE),
        .TIMEOUT_CYC (TMO),
        .GAP_W       (16)
    ) dut (
        .clk_1d024M      (clk),
        .rst_n_1d024M    (rst_n),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_mode        (cfg_mode),
        .cfg_phase       (cfg_phase),
        .cfg_delay       (cfg_delay),
        .cfg_burst_len   (cfg_burst_len),
        .cfg_gap         (cfg_gap),
        .run             (run),
        .abort           (abort),
        .tx_frame_done   (tx_frame_done),
        .MODE_CTRL       (MODE_CTRL),
        .TX_PHASE_CONFIG (TX_PHASE_CONFIG),
        .DELAY_CNT       (DELAY_CNT),
        .tx_en           (tx_en),
        .tx_start        (tx_start),
        .busy            (busy),
        .burst_done      (burst_done),
        .frame_cnt       (frame_cnt),
        .err             (err)
    );

    int checks   = 0;
    int failures = 0;
    int now      = 0;

    // Tx responder
    int lat           = 10;
    int done_at       = -1;
    bit noise         = 1'b0;
    bit abort_on_done = 1'b0;
    int starts[$];

    // reference model state
    int         m_ph = P_OFF;
    bit         m_ready, m_loaded, m_err, m_bd;
    logic [1:0] m_mode, m_phs;
    logic [7:0] m_delay, m_len, m_cnt;
    logic [15:0] m_gap;
    int         launch_at, fault_at;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d",
                     tag, got, exp, now);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {6'd0, cfg_ready, MODE_CTRL, TX_PHASE_CONFIG, DELAY_CNT,
                tx_en, tx_start, busy, burst_done, frame_cnt, err};
    endfunction

    function automatic logic [31:0] exp_vec();
        logic en;
        en = (m_ph == P_SETTLE) || (m_ph == P_LAUNCH) ||
             (m_ph == P_FLIGHT) || (m_ph == P_REST);
        return {6'd0, m_ready, m_mode, m_phs, m_delay, en,
                m_ph == P_LAUNCH, m_ph != P_OFF, m_bd, m_cnt, m_err};
    endfunction

    // advance the model across one edge using this cycle's inputs
    task automatic model_step();
        bit hs, fd, bd;
        int nx;
        if (!rst_n) begin
            m_ph = P_OFF; m_ready = 0; m_loaded = 0; m_err = 0; m_bd = 0;
            m_mode = 0; m_phs = 0; m_delay = 0; m_len = 0; m_gap = 0;
            m_cnt = 0;
            return;
        end
        hs = cfg_valid && m_ready;
        fd = (m_ph == P_FLIGHT) && tx_frame_done;
        nx = m_ph;
        bd = 0;
        if (fd) m_cnt = m_cnt + 8'd1;
        if (abort) begin
            nx = P_OFF;
        end else begin
            case (m_ph)
                P_OFF: if (run && m_loaded && !m_err && !hs) begin
                    nx = P_SETTLE;
                    launch_at = now + 1 + SETTLE;
                    m_cnt = 8'd0;
                end
                P_SETTLE: if (now + 1 == launch_at) nx = P_LAUNCH;
                P_LAUNCH: nx = P_FLIGHT;
                P_FLIGHT: begin
                    if (fd) begin
                        if (m_len != 8'd0 && m_cnt == m_len) begin
                            nx = P_OFF;
                            bd = 1;
                        end else if (!run) begin
                            nx = P_OFF;
                        end else if (m_gap == 16'd0) begin
                            nx = P_LAUNCH;
                        end else begin
                            nx = P_REST;
                            launch_at = now + 1 + int'(m_gap);
                        end
                    end else if (now + 1 == fault_at) begin
                        nx = P_FAULT;
                        m_err = 1;
                    end
                end
                P_REST: if (now + 1 == launch_at) nx = run ? P_LAUNCH : P_OFF;
                P_FAULT: if (!run) nx = P_OFF;
                default: nx = P_OFF;
            endcase
            if (nx == P_LAUNCH) fault_at = now + 1 + TMO;
        end
        if (hs) begin
            m_mode = cfg_mode; m_phs = cfg_phase; m_delay = cfg_delay;
            m_len = cfg_burst_len; m_gap = cfg_gap;
            m_loaded = 1; m_err = 0;
        end
        m_ph = nx;
        m_bd = bd;
        m_ready = (nx == P_OFF);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        now++;
        chk("outs", dut_vec(), exp_vec());
        if (tx_start) begin
            starts.push_back(now);
            done_at = (lat > 0) ? now + lat : -1;
        end
        @(negedge clk);
        tx_frame_done = (now == done_at) ||
                        (noise && $urandom_range(0, 31) == 0);
        if (now == done_at && abort_on_done) abort = 1'b1;
    endtask

    task automatic offer(input logic [1:0] md, input logic [1:0] ph,
                         input logic [7:0] dl, input logic [7:0] bl,
                         input logic [15:0] gp);
        cfg_valid = 1'b1;
        cfg_mode = md; cfg_phase = ph; cfg_delay = dl;
        cfg_burst_len = bl; cfg_gap = gp;
        tick();
        cfg_valid = 1'b0;
    endtask

    initial begin
        int n;
        int arm_at;
        rst_n = 0; cfg_valid = 0; cfg_mode = 0; cfg_phase = 0;
        cfg_delay = 0; cfg_burst_len = 0; cfg_gap = 0;
        run = 0; abort = 0; tx_frame_done = 0;

        repeat (3) tick();
        chk("rst_outs", dut_vec(), 32'd0);
        rst_n = 1;
        tick();

        // burst of 3 with gap 4
        offer(2'd1, 2'd2, 8'd5, 8'd3, 16'd4);
        run = 1;
        starts.delete();
        n = 0;
        while (!busy && n < 10) begin tick(); n++; end
        arm_at = now;
        n = 0;
        while (!burst_done && n < 200) begin tick(); n++; end
        run = 0;
        chk("t1_bd", 32'(burst_done), 1);
        chk("t1_cnt", 32'(frame_cnt), 3);
        chk("t1_mode", 32'(MODE_CTRL), 1);
        chk("t1_nstarts", starts.size(), 3);
        if (starts.size() == 3) begin
            chk("t1_settle", starts[0] - arm_at, 16);
            chk("t1_gap1", starts[1] - starts[0], 15);
            chk("t1_gap2", starts[2] - starts[1], 15);
        end

        // config offered while busy
        run = 1;
        tick();
        cfg_valid = 1; cfg_mode = 2'd3; cfg_phase = 2'd1;
        cfg_delay = 8'd9; cfg_burst_len = 8'd2; cfg_gap = 16'd0;
        repeat (20) tick();
        chk("t2_ready_busy", 32'(cfg_ready), 0);
        chk("t2_mode_hold", 32'(MODE_CTRL), 1);
        run = 0;
        n = 0;
        while (!cfg_ready && n < 50) begin tick(); n++; end
        chk("t2_ready_idle", 32'(cfg_ready), 1);
        tick();
        cfg_valid = 0;
        chk("t2_mode_new", 32'(MODE_CTRL), 3);

        // continuous back-to-back, 300 frames
        offer(2'd0, 2'd0, 8'd7, 8'd0, 16'd0);
        run = 1;
        starts.delete();
        n = 0;
        while (starts.size() < 300 && n < 3500) begin tick(); n++; end
        run = 0;
        n = 0;
        while (busy && n < 50) begin tick(); n++; end
        chk("t3_nstarts", starts.size(), 300);
        chk("t3_cnt", 32'(frame_cnt), 44);
        chk("t3_idle", 32'(busy), 0);
        if (starts.size() >= 300)
            chk("t3_span", starts[299] - starts[0], 299 * 11);

        // watchdog
        offer(2'd2, 2'd0, 8'd1, 8'd2, 16'd3);
        lat = 0;
        run = 1;
        starts.delete();
        n = 0;
        while (!err && n < 4300) begin tick(); n++; end
        chk("t4_err", 32'(err), 1);
        chk("t4_en", 32'(tx_en), 0);
        if (starts.size() == 1)
            chk("t4_latency", now - starts[0], TMO);
        repeat (10) tick();
        chk("t4_busy_err", 32'(busy), 1);
        run = 0;
        repeat (2) tick();
        chk("t4_idle", 32'(busy), 0);
        run = 1;
        repeat (20) tick();
        chk("t4_stuck", 32'(busy), 0);
        chk("t4_sticky", 32'(err), 1);
        run = 0;
        offer(2'd2, 2'd0, 8'd1, 8'd5, 16'd4);
        chk("t4_clear", 32'(err), 0);
        lat = 10;

        // abort in ARM
        run = 1;
        starts.delete();
        n = 0;
        while (!busy && n < 10) begin tick(); n++; end
        repeat (5) tick();
        abort = 1; run = 0;
        tick();
        abort = 0;
        chk("t5a_idle", 32'(busy), 0);
        repeat (20) tick();
        chk("t5a_nostart", starts.size(), 0);

        // abort in GAP
        run = 1;
        n = 0;
        while (frame_cnt != 8'd1 && n < 80) begin tick(); n++; end
        tick();
        abort = 1; run = 0;
        tick();
        abort = 0;
        chk("t5b_idle", 32'(busy), 0);
        chk("t5b_cnt", 32'(frame_cnt), 1);
        repeat (20) tick();
        chk("t5b_nostart", starts.size(), 1);

        // abort with the done pulse
        run = 1;
        abort_on_done = 1;
        starts.delete();
        n = 0;
        while (starts.size() < 1 && n < 40) begin tick(); n++; end
        n = 0;
        while (busy && n < 40) begin tick(); n++; end
        abort = 0; abort_on_done = 0; run = 0;
        chk("t5c_idle", 32'(busy), 0);
        chk("t5c_cnt", 32'(frame_cnt), 1);
        chk("t5c_bd", 32'(burst_done), 0);
        repeat (15) tick();
        chk("t5c_nostart", starts.size(), 1);

        // reset mid-frame
        run = 1;
        starts.delete();
        n = 0;
        while (starts.size() < 1 && n < 40) begin tick(); n++; end
        repeat (3) tick();
        rst_n = 0;
        tick();
        chk("t6_rst", dut_vec(), 32'd0);
        rst_n = 1;
        repeat (40) tick();
        chk("t6_noarm", 32'(busy), 0);
        offer(2'd3, 2'd3, 8'd2, 8'd4, 16'd2);
        repeat (3) tick();
        chk("t6_rearm", 32'(busy), 1);

        // random traffic
        noise = 1;
        for (int i = 0; i < 4000; i++) begin
            lat = $urandom_range(1, 14);
            if ($urandom_range(0, 39) == 0) run = ~run;
            abort = ($urandom_range(0, 63) == 0);
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_mode = 2'($urandom);
            cfg_phase = 2'($urandom);
            cfg_delay = 8'($urandom);
            cfg_burst_len = 8'($urandom_range(0, 4));
            cfg_gap = 16'($urandom_range(0, 5));
            rst_n = ($urandom_range(0, 599) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
